calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Control sequencer between the keypad decoder and the decimal adder datapath (`module_suma`). It buffers decoded key events and enforces the operand entry protocol: at most `DIGITS_MAX` digits per operand, with operator keys ignored where they are illegal. It forwards legal keys to the adder as single-cycle pulses, waits for the adder's acknowledge, then hands the sum to the binary-to-BCD converter. It also selects what the display shows.

## Interface
Parameters:
- `DIGITS_MAX`, 3: max digits per operand, so the sum stays ≤ 1998.
- `FIFO_DEPTH`, 4: key queue depth, power of 2.
- `RESULT_WIDTH`, 14: width of the adder result and display value.
- `ACK_TIMEOUT`, 8: cycles to wait for `add_result_pulse`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset. The adder's active-low reset is driven as `~rst` at top level.
- `key_valid` in 1: one-cycle strobe from the keypad decoder.
- `key_code` in 4: 0–9 digit, 10 ADD, 11 EQUAL, 12 CLEAR, 13–15 unused.
- `add_key_code` out 4: key forwarded to the adder.
- `add_key_pulse` out 1: one-cycle forward strobe.
- `add_result_pulse` in 1: adder acknowledge for ADD/EQUAL.
- `add_result` in RESULT_WIDTH: adder sum.
- `bcd_start` out 1: one-cycle conversion start.
- `bcd_done` in 1: conversion complete strobe.
- `disp_value` out RESULT_WIDTH: value shown on the display.
- `disp_sel` out 2: 0 = operand A, 1 = operand B, 2 = result.
- `err` out 1: one-cycle pulse on timeout or rejected digit.
- `key_dropped` out 1: one-cycle pulse when `key_valid` arrives with the FIFO full.

## Operation
- **Key FIFO.**
  - `key_valid` pushes `key_code`. Codes 13–15 are never pushed.
  - When full, the key is dropped and `key_dropped` pulses, even if a pop happens in the same cycle.
  - The head is popped only in ENTER_A, ENTER_B and SHOW, at most one key per cycle. Keys wait in the FIFO during WAIT_ADD, WAIT_EQ and CONVERT.
- **Shadow operand.** `cnt` holds the digit count. `shadow` holds the value being typed: each accepted digit sets `shadow = shadow*10 + d`. `disp_value = shadow` in ENTER_A and ENTER_B.
- **States:**
  - ENTER_A (reset state):
    - digit with `cnt < DIGITS_MAX`: forward it, `cnt++`.
    - digit with `cnt == DIGITS_MAX`: discard, pulse `err`.
    - ADD with `cnt > 0`: forward, go to WAIT_ADD.
    - ADD with `cnt == 0`: discard.
    - EQUAL: discard.
  - WAIT_ADD:
    - on `add_result_pulse`: `cnt = 0`, `shadow = 0`, go to ENTER_B.
    - after `ACK_TIMEOUT` cycles with no acknowledge: pulse `err`, forward CLEAR, go to ENTER_A.
  - ENTER_B:
    - digits: same rules as ENTER_A.
    - ADD: discard.
    - EQUAL with `cnt > 0`: forward, go to WAIT_EQ.
    - EQUAL with `cnt == 0`: discard.
  - WAIT_EQ:
    - on `add_result_pulse`: latch `add_result` into `res_q`, pulse `bcd_start`, go to CONVERT.
    - timeout: same as WAIT_ADD.
  - CONVERT: on `bcd_done` go to SHOW. No timeout.
  - SHOW: `disp_value = res_q`.
    - digit: forward it, `cnt = 1`, `shadow = d`, go to ENTER_A.
    - ADD, EQUAL: discard.
- **CLEAR** popped in ENTER_A, ENTER_B or SHOW: forward it, zero `cnt`, `shadow` and `res_q`, go to ENTER_A.
- **Display select.** `disp_sel` is 0 in ENTER_A and WAIT_ADD, 1 in ENTER_B and WAIT_EQ, 2 in CONVERT and SHOW.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, `disp_sel` = 0, state ENTER_A, FIFO empty, `cnt`/`shadow`/`res_q`/timer = 0.
- Latency with the FIFO empty in an entry state:
  - `key_valid` at cycle t → pop at t+1 → `add_key_pulse` at t+2.
  - Back-to-back keys forward on consecutive cycles.
- `add_key_code` holds its value between pulses.
- The ack timer starts the cycle after an ADD/EQUAL is forwarded.
- `add_result_pulse` outside WAIT_ADD and WAIT_EQ is ignored.
- `bcd_start` is asserted one cycle after the EQUAL acknowledge.
- Reset asserted mid-operation clears everything asynchronously, including queued keys.

## Structure
- Package `calc_pkg` holds:
  - key constants `KEY_ADD = 4'd10`, `KEY_EQ = 4'd11`, `KEY_CLR = 4'd12`;
  - the state enum `seq_state_t`;
  - the `disp_sel` encodings `DISP_A`, `DISP_B`, `DISP_RES`.
- Sub-module `key_fifo`: synchronous FIFO with depth `FIFO_DEPTH`, async active-high reset, and push/pop/full/empty/head ports.
- The state machine, counters and timer stay in `calc_sequencer`.

## Test plan
- **Basic sum.** Keys 1,2,3,ADD,4,5,EQUAL with an adder model that acks one cycle after each strobe.
  - Forwarded codes are 1,2,3,10,4,5,11.
  - `bcd_start` fires once; `disp_value` = 168 with `disp_sel` = 2 after `bcd_done`.
- **Digit limit.** Keys 9,9,9,9,ADD,9,9,9,EQUAL.
  - The 4th 9 is not forwarded and `err` pulses.
  - Result is 1998.
- **Illegal operators.**
  - ADD with no digits entered is not forwarded.
  - EQUAL in ENTER_A is not forwarded.
  - ADD in ENTER_B is not forwarded.
  - The state is unchanged in each case.
- **FIFO overflow.** Five `key_valid` events during WAIT_ADD with the ack held off.
  - The 5th key pulses `key_dropped`.
  - The first 4 are forwarded in order after the ack.
- **Timeout.** No ack after ADD.
  - `err` pulses 8 cycles later.
  - CLEAR is forwarded and the state returns to ENTER_A with `disp_sel` = 0.
- **Reset mid-CONVERT, then restart.**
  - `rst` during CONVERT: all outputs return to 0 immediately.
  - Separately, a digit 7 entered in SHOW is forwarded, `disp_value` = 7 and `disp_sel` = 0.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Key codes, sequencer states and display encodings shared by
//               the calculator control path.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_EQ  = 4'd11;
    localparam logic [3:0] KEY_CLR = 4'd12;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_RES = 2'd2;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_WAIT_ADD = 3'd1,
        ST_ENTER_B  = 3'd2,
        ST_WAIT_EQ  = 3'd3,
        ST_CONVERT  = 3'd4,
        ST_SHOW     = 3'd5
    } seq_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_fifo
// Description : Small synchronous FIFO buffering decoded key events.
// Revision    : 1.0 - initial release
// ============================================================================
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign o_head    = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_sequencer
// Description : Operand-entry sequencer between keypad decoder, decimal adder
//               and binary-to-BCD converter; also drives the display source.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
    parameter int DIGITS_MAX   = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int RESULT_WIDTH = 14,
    parameter int ACK_TIMEOUT  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic [3:0]              add_key_code,
    output logic                    add_key_pulse,
    input  logic                    add_result_pulse,
    input  logic [RESULT_WIDTH-1:0] add_result,
    output logic                    bcd_start,
    input  logic                    bcd_done,
    output logic [RESULT_WIDTH-1:0] disp_value,
    output logic [1:0]              disp_sel,
    output logic                    err,
    output logic                    key_dropped
);

    import calc_pkg::*;

    localparam int c_cnt_w = $clog2(DIGITS_MAX + 1);
    localparam int c_tmr_w = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DIGITS_MAX);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(ACK_TIMEOUT - 1);

    seq_state_t              r_state, w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
    logic [RESULT_WIDTH-1:0] r_shadow, w_shadow_nxt;
    logic [RESULT_WIDTH-1:0] r_res, w_res_nxt;
    logic [c_tmr_w-1:0]      r_timer, w_timer_nxt;

    logic [3:0]              r_add_key_code;
    logic                    r_add_key_pulse;
    logic                    r_bcd_start;
    logic [RESULT_WIDTH-1:0] r_disp_value;
    logic [1:0]              r_disp_sel;
    logic                    r_err;
    logic                    r_key_dropped;

    logic                    w_key_ok, w_push, w_drop, w_pop;
    logic [3:0]              w_head;
    logic                    w_full, w_empty;
    logic                    w_fwd, w_err, w_bcd_start, w_clear;
    logic [3:0]              w_fwd_code;
    logic [RESULT_WIDTH-1:0] w_digit_ext, w_shadow_x10;
    logic [RESULT_WIDTH-1:0] w_disp_val_nxt;
    logic [1:0]              w_disp_sel_nxt;

    // A full FIFO drops the key even when the head is popped this cycle.
    assign w_key_ok = key_valid && (key_code <= KEY_CLR);
    assign w_push   = w_key_ok && !w_full;
    assign w_drop   = w_key_ok && w_full;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_key_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (key_code),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_digit_ext  = {{(RESULT_WIDTH-4){1'b0}}, w_head};
    assign w_shadow_x10 = (r_shadow << 3) + (r_shadow << 1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_res_nxt    = r_res;
        w_timer_nxt  = '0;
        w_pop        = 1'b0;
        w_fwd        = 1'b0;
        w_fwd_code   = w_head;
        w_err        = 1'b0;
        w_bcd_start  = 1'b0;
        w_clear      = 1'b0;

        case (r_state)
            ST_ENTER_A, ST_ENTER_B, ST_SHOW: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head == KEY_CLR) begin
                        w_clear = 1'b1;
                    end else if (is_digit(w_head)) begin
                        if (r_state == ST_SHOW) begin
                            w_fwd        = 1'b1;
                            w_cnt_nxt    = c_cnt_w'(1);
                            w_shadow_nxt = w_digit_ext;
                            w_state_nxt  = ST_ENTER_A;
                        end else if (r_cnt < c_cnt_max) begin
                            w_fwd        = 1'b1;
                            w_cnt_nxt    = r_cnt + c_cnt_w'(1);
                            w_shadow_nxt = w_shadow_x10 + w_digit_ext;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else if (r_cnt != '0) begin
                        if (r_state == ST_ENTER_A && w_head == KEY_ADD) begin
                            w_fwd       = 1'b1;
                            w_state_nxt = ST_WAIT_ADD;
                        end else if (r_state == ST_ENTER_B && w_head == KEY_EQ) begin
                            w_fwd       = 1'b1;
                            w_state_nxt = ST_WAIT_EQ;
                        end
                    end
                end
            end
            ST_WAIT_ADD, ST_WAIT_EQ: begin
                if (add_result_pulse) begin
                    if (r_state == ST_WAIT_ADD) begin
                        w_cnt_nxt    = '0;
                        w_shadow_nxt = '0;
                        w_state_nxt  = ST_ENTER_B;
                    end else begin
                        w_res_nxt   = add_result;
                        w_bcd_start = 1'b1;
                        w_state_nxt = ST_CONVERT;
                    end
                end else if (r_timer == c_tmr_last) begin
                    w_err   = 1'b1;
                    w_clear = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + c_tmr_w'(1);
                end
            end
            ST_CONVERT: begin
                if (bcd_done) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            default: begin
                w_state_nxt = ST_ENTER_A;
            end
        endcase

        // Abandoning an operation tells the adder to clear as well.
        if (w_clear) begin
            w_fwd        = 1'b1;
            w_fwd_code   = KEY_CLR;
            w_cnt_nxt    = '0;
            w_shadow_nxt = '0;
            w_res_nxt    = '0;
            w_state_nxt  = ST_ENTER_A;
        end
    end

    always_comb begin
        w_disp_sel_nxt = DISP_A;
        w_disp_val_nxt = w_shadow_nxt;
        case (w_state_nxt)
            ST_ENTER_B, ST_WAIT_EQ: begin
                w_disp_sel_nxt = DISP_B;
            end
            ST_CONVERT, ST_SHOW: begin
                w_disp_sel_nxt = DISP_RES;
                w_disp_val_nxt = w_res_nxt;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_ENTER_A;
            r_cnt           <= '0;
            r_shadow        <= '0;
            r_res           <= '0;
            r_timer         <= '0;
            r_add_key_code  <= '0;
            r_add_key_pulse <= 1'b0;
            r_bcd_start     <= 1'b0;
            r_disp_value    <= '0;
            r_disp_sel      <= DISP_A;
            r_err           <= 1'b0;
            r_key_dropped   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_shadow        <= w_shadow_nxt;
            r_res           <= w_res_nxt;
            r_timer         <= w_timer_nxt;
            r_add_key_pulse <= w_fwd;
            if (w_fwd) begin
                r_add_key_code <= w_fwd_code;
            end
            r_bcd_start     <= w_bcd_start;
            r_disp_value    <= w_disp_val_nxt;
            r_disp_sel      <= w_disp_sel_nxt;
            r_err           <= w_err;
            r_key_dropped   <= w_drop;
        end
    end

    assign add_key_code  = r_add_key_code;
    assign add_key_pulse = r_add_key_pulse;
    assign bcd_start     = r_bcd_start;
    assign disp_value    = r_disp_value;
    assign disp_sel      = r_disp_sel;
    assign err           = r_err;
    assign key_dropped   = r_key_dropped;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Scoreboard bench for calc_sequencer with adder/BCD models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int RW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [3:0]    key_code;
    logic [3:0]    add_key_code;
    logic          add_key_pulse;
    logic          add_result_pulse;
    logic [RW-1:0] add_result;
    logic          bcd_start;
    logic          bcd_done;
    logic [RW-1:0] disp_value;
    logic [1:0]    disp_sel;
    logic          err;
    logic          key_dropped;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int drop_cnt = 0;
    int bcd_cnt  = 0;
    int e0, d0;
    int m_a = 0, m_op = 0;
    bit ack_en = 1'b1, bcd_en = 1'b1, ack_due = 1'b0, bcd_due = 1'b0;

    logic [3:0] exp_q[$];
    logic [3:0] stim_q[$];

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .add_key_code     (add_key_code),
        .add_key_pulse    (add_key_pulse),
        .add_result_pulse (add_result_pulse),
        .add_result       (add_result),
        .bcd_start        (bcd_start),
        .bcd_done         (bcd_done),
        .disp_value       (disp_value),
        .disp_sel         (disp_sel),
        .err              (err),
        .key_dropped      (key_dropped)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every forwarded key is checked against the scoreboard queue.
    always @(negedge clk) begin
        if (err)         err_cnt++;
        if (key_dropped) drop_cnt++;
        if (bcd_start)   bcd_cnt++;
        if (add_key_pulse) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fwd_unexpected: got code %0d expected no forward", add_key_code);
            end else begin
                chk("fwd_code", int'(add_key_code), int'(exp_q.pop_front()));
            end
        end
    end

    // Adder and converter models: acknowledge one cycle after the strobe.
    always @(negedge clk) begin
        if (rst) begin
            m_a  = 0;
            m_op = 0;
        end else if (add_key_pulse) begin
            case (add_key_code)
                KEY_ADD: begin m_a = m_op; m_op = 0; if (ack_en) ack_due = 1'b1; end
                KEY_EQ:  begin add_result = RW'(m_a + m_op); m_a = 0; m_op = 0;
                               if (ack_en) ack_due = 1'b1; end
                KEY_CLR: begin m_a = 0; m_op = 0; end
                default: m_op = m_op * 10 + int'(add_key_code);
            endcase
        end
        if (bcd_start && bcd_en) bcd_due = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        add_result_pulse = ack_due;
        ack_due          = 1'b0;
        bcd_done         = bcd_due;
        bcd_due          = 1'b0;
    end

    task automatic press(input logic [3:0] c, input bit fwd);
        if (fwd) exp_q.push_back(c);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic key(input logic [3:0] c, input bit fwd);
        stim_q.push_back(c);
        if (fwd) exp_q.push_back(c);
    endtask

    task automatic burst();
        @(posedge clk); #1;
        while (stim_q.size() > 0) begin
            key_valid = 1'b1;
            key_code  = stim_q.pop_front();
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
        add_result_pulse = 1'b0; add_result = '0; bcd_done = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pulse", int'(add_key_pulse), 0);
        chk("rst_code", int'(add_key_code), 0);
        chk("rst_disp_value", int'(disp_value), 0);
        chk("rst_disp_sel", int'(disp_sel), 0);
        chk("rst_err", int'(err | bcd_start | key_dropped), 0);

        // Basic sum 123 + 45, including latency and back-to-back forwarding
        press(4'd1, 1'b1);
        @(negedge clk); chk("latency_t1", int'(add_key_pulse), 0);
        @(negedge clk); chk("latency_t2", int'(add_key_pulse), 1);
        @(posedge clk); #1; key_valid = 1'b1; key_code = 4'd2; exp_q.push_back(4'd2);
        @(posedge clk); #1; key_code = 4'd3; exp_q.push_back(4'd3);
        @(posedge clk); #1; key_valid = 1'b0;
        @(negedge clk); chk("b2b_first", int'(add_key_pulse), 1);
        @(negedge clk); chk("b2b_second", int'(add_key_pulse), 1);
        key(KEY_ADD, 1); key(4'd4, 1); key(4'd5, 1); key(KEY_EQ, 1);
        burst();
        idle(30);
        chk("sum_bcd_starts", bcd_cnt, 1);
        chk("sum_disp_value", int'(disp_value), 168);
        chk("sum_disp_sel", int'(disp_sel), 2);

        // Digit limit 999 + 999
        press(KEY_CLR, 1'b1);
        e0 = err_cnt; d0 = drop_cnt;
        key(4'd9, 1); key(4'd9, 1); key(4'd9, 1); key(4'd9, 0); key(KEY_ADD, 1);
        key(4'd9, 1); key(4'd9, 1); key(4'd9, 1); key(KEY_EQ, 1);
        burst();
        idle(30);
        chk("limit_err", err_cnt - e0, 1);
        chk("limit_no_drop", drop_cnt - d0, 0);
        chk("limit_result", int'(disp_value), 1998);
        chk("limit_bcd_starts", bcd_cnt, 2);

        // Illegal operators are discarded without changing state
        e0 = err_cnt;
        press(KEY_CLR, 1'b1);
        press(KEY_ADD, 1'b0);
        press(KEY_EQ, 1'b0);
        idle(3);
        chk("illegal_a_sel", int'(disp_sel), 0);
        chk("illegal_a_queue", exp_q.size(), 0);
        press(4'd5, 1'b1);
        press(KEY_ADD, 1'b1);
        idle(5);
        chk("enter_b_sel", int'(disp_sel), 1);
        press(KEY_ADD, 1'b0);
        idle(3);
        chk("illegal_b_sel", int'(disp_sel), 1);
        press(4'd6, 1'b1);
        press(KEY_EQ, 1'b1);
        idle(10);
        chk("illegal_result", int'(disp_value), 11);
        chk("illegal_no_err", err_cnt - e0, 0);

        // FIFO overflow while the ADD acknowledge is held off
        press(KEY_CLR, 1'b1);
        press(4'd2, 1'b1);
        ack_en = 1'b0;
        press(KEY_ADD, 1'b1);
        d0 = drop_cnt;
        key(4'd1, 1); key(4'd2, 1); key(4'd3, 1); key(KEY_EQ, 1); key(4'd7, 0);
        burst();
        ack_en = 1'b1;
        @(negedge clk); ack_due = 1'b1;
        idle(20);
        chk("overflow_drop", drop_cnt - d0, 1);
        chk("overflow_result", int'(disp_value), 125);

        // Acknowledge timeout
        press(KEY_CLR, 1'b1);
        press(4'd3, 1'b1);
        ack_en = 1'b0;
        press(KEY_ADD, 1'b1);
        exp_q.push_back(KEY_CLR);
        e0 = err_cnt;
        @(negedge clk);
        @(negedge clk); chk("timeout_add_fwd", int'(add_key_pulse), 1);
        repeat (7) @(negedge clk);
        chk("timeout_early", int'(err), 0);
        @(negedge clk);
        chk("timeout_err", int'(err), 1);
        chk("timeout_clr_pulse", int'(add_key_pulse), 1);
        ack_en = 1'b1;
        idle(2);
        chk("timeout_sel", int'(disp_sel), 0);
        chk("timeout_err_once", err_cnt - e0, 1);

        // Restart from SHOW with a digit
        key(4'd4, 1); key(KEY_ADD, 1); key(4'd5, 1); key(KEY_EQ, 1);
        burst();
        idle(20);
        chk("show_result", int'(disp_value), 9);
        press(4'd7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("restart_value", int'(disp_value), 7);
        chk("restart_sel", int'(disp_sel), 0);

        // Reset during CONVERT with a key still queued
        bcd_en = 1'b0;
        key(KEY_ADD, 1); key(4'd1, 1); key(KEY_EQ, 1);
        burst();
        idle(15);
        chk("convert_sel", int'(disp_sel), 2);
        chk("convert_value", int'(disp_value), 8);
        press(4'd5, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sel", int'(disp_sel), 0);
        chk("async_rst_value", int'(disp_value), 0);
        chk("async_rst_code", int'(add_key_code), 0);
        chk("async_rst_pulses", int'(add_key_pulse | bcd_start | err | key_dropped), 0);
        idle(2);
        bcd_en = 1'b1;
        rst = 1'b0;
        idle(6);
        chk("post_rst_sel", int'(disp_sel), 0);
        press(4'd8, 1'b1);
        idle(3);
        chk("post_rst_value", int'(disp_value), 8);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
